// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams instruction words into CPU imem, holding the CPU in reset until loaded.
// Define PAD_HALT_EN to fill unused words up to DEPTH with HALT_WORD before release.
module imem_boot_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int ADDR_STRIDE = 4,
  parameter int HOLD_CYCLES = 2,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'h1000FFFF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              initialize,
  output logic [ADDR_W-1:0] instruction_initialize_address,
  output logic [DATA_W-1:0] instruction_initialize_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [CW-1:0]     word_count
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
`ifdef PAD_HALT_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, PAD, RELEASE, RUN, ERR} state_t;
  state_t state, nxt_state;
  logic [HW-1:0] hold, nxt_hold;
  logic last_seen, nxt_last, nxt_init, nxt_cpu_rst, nxt_done, nxt_err, wr;
  logic [ADDR_W-1:0] nxt_addr, word_addr;
  logic [DATA_W-1:0] nxt_data, wr_data;
  logic [CW-1:0] nxt_cnt;
  // word_count doubles as the index of the next word to write
  assign word_addr = BASE_ADDR + ADDR_W'(word_count) * ADDR_W'(ADDR_STRIDE);
  assign s_ready = state == LOAD && hold == '0 && !last_seen;
  always_comb begin
    nxt_state = state;
    nxt_hold = hold == '0 ? hold : hold - 1'b1;
    nxt_last = last_seen;
    nxt_init = initialize;
    nxt_cpu_rst = cpu_rst;
    nxt_done = done;
    nxt_err = error;
    nxt_addr = instruction_initialize_address;
    nxt_data = instruction_initialize_data;
    nxt_cnt = word_count;
    wr = 1'b0;
    wr_data = s_data;
    case (state)
      IDLE, RUN, ERR: if (start) begin
        nxt_state = LOAD;
        nxt_hold = '0;
        nxt_last = 1'b0;
        nxt_init = 1'b1;
        nxt_cpu_rst = 1'b1;
        nxt_done = 1'b0;
        nxt_err = 1'b0;
        nxt_addr = BASE_ADDR;
        nxt_cnt = '0;
      end
      LOAD: if (s_valid && s_ready) begin
        wr = 1'b1;
        nxt_last = s_last;
        if (!s_last && word_count == CW'(DEPTH - 1)) begin
          nxt_state = ERR;
          nxt_err = 1'b1;
        end
      end else if (last_seen && hold == '0) nxt_state = PAD_EN ? PAD : RELEASE;
      PAD: if (hold == '0) begin
        if (word_count == CW'(DEPTH)) nxt_state = RELEASE;
        else begin
          wr = 1'b1;
          wr_data = HALT_WORD;
        end
      end
      RELEASE: begin
        nxt_state = RUN;
        nxt_init = 1'b0;
        nxt_cpu_rst = 1'b0;
        nxt_done = 1'b1;
      end
      default: ;
    endcase
    if (wr) begin
      nxt_addr = word_addr;
      nxt_data = wr_data;
      nxt_cnt = word_count + 1'b1;
      nxt_hold = HW'(HOLD_CYCLES);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      hold <= '0;
      last_seen <= 1'b0;
      initialize <= 1'b1;
      cpu_rst <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      instruction_initialize_address <= BASE_ADDR;
      instruction_initialize_data <= '0;
      word_count <= '0;
    end else begin
      state <= nxt_state;
      hold <= nxt_hold;
      last_seen <= nxt_last;
      initialize <= nxt_init;
      cpu_rst <= nxt_cpu_rst;
      done <= nxt_done;
      error <= nxt_err;
      instruction_initialize_address <= nxt_addr;
      instruction_initialize_data <= nxt_data;
      word_count <= nxt_cnt;
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: random program streams checked against the loader's address/hold/release rules.
module tb_imem_boot_loader;
  localparam int DW = 32, AW = 32, DEPTH = 8, HOLD = 2, STRIDE = 4, CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] BASE = 32'h100;
  localparam logic [DW-1:0] HALT = 32'h1000FFFF;
  logic clk = 0, rst = 0, start = 0, s_valid = 0, s_last = 0;
  logic s_ready, initialize, cpu_rst, done, error;
  logic [DW-1:0] s_data = '0, imem_data;
  logic [AW-1:0] imem_addr;
  logic [CW-1:0] word_count;
  logic [DW-1:0] prog [16];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  imem_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .ADDR_STRIDE(STRIDE), .HOLD_CYCLES(HOLD), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .initialize(initialize),
    .instruction_initialize_address(imem_addr), .instruction_initialize_data(imem_data),
    .cpu_rst(cpu_rst), .done(done), .error(error), .word_count(word_count));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [AW-1:0] waddr(input int i);
    return BASE + AW'(i * STRIDE);
  endfunction
  task automatic reset_values(input string tag);
    check({tag, "_init"}, 64'(initialize), 64'd1);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, "_addr"}, 64'(imem_addr), 64'(BASE));
    check({tag, "_data"}, 64'(imem_data), 64'd0);
    check({tag, "_rdy"}, 64'(s_ready), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(error), 64'd0);
    check({tag, "_wc"}, 64'(word_count), 64'd0);
  endtask
  task automatic load(input int n, input bit term, input int abort_at);
    bit early, erred;
    int gap, cyc, pads;
    logic [AW-1:0] last_a;
    for (int i = 0; i < n; i++) prog[i] = $urandom;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_init", 64'(initialize), 64'd1);
    check("start_cpu_rst", 64'(cpu_rst), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_err", 64'(error), 64'd0);
    check("start_wc", 64'(word_count), 64'd0);
    check("start_addr", 64'(imem_addr), 64'(BASE));
    early = 0;
    erred = 0;
    for (int i = 0; i < n; i++) begin
      if (!early) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          check("gap_rdy", 64'(s_ready), 64'd1);
          @(negedge clk);
        end
        s_valid = 1;
        s_data = prog[i];
        s_last = term && i == n - 1;
      end
      check("acc_rdy", 64'(s_ready), 64'd1);
      @(negedge clk);
      for (int k = 1; k <= HOLD; k++) begin
        if (k > 1) @(negedge clk);
        check("addr", 64'(imem_addr), 64'(waddr(i)));
        check("data", 64'(imem_data), 64'(prog[i]));
        check("wc", 64'(word_count), 64'(i + 1));
        check("hold_rdy", 64'(s_ready), 64'd0);
        if (k == 1) begin
          check("err", 64'(error), 64'(!term && i == DEPTH - 1));
          early = i < n - 1 && $urandom_range(0, 1) == 1;
          s_valid = early;
          s_data = early ? prog[i + 1] : $urandom;
          s_last = early && term && i + 1 == n - 1;
          if (i == abort_at) begin
            rst = 0;
            s_valid = 0;
            #1 reset_values("abort");
            @(negedge clk);
            rst = 1;
            return;
          end
        end
      end
      if (!term && i == DEPTH - 1) begin
        erred = 1;
        break;
      end
      if (i < n - 1) @(negedge clk);
    end
    if (erred) begin
      s_valid = 1;
      s_data = $urandom;
      s_last = 0;
      repeat (4) begin
        @(negedge clk);
        check("err_sticky", 64'(error), 64'd1);
        check("err_rdy", 64'(s_ready), 64'd0);
        check("err_cpu_rst", 64'(cpu_rst), 64'd1);
        check("err_init", 64'(initialize), 64'd1);
        check("err_wc", 64'(word_count), 64'(DEPTH));
        check("err_addr", 64'(imem_addr), 64'(waddr(DEPTH - 1)));
      end
      s_valid = 0;
      return;
    end
    s_valid = 0;
    s_last = 0;
    pads = 0;
    cyc = 0;
    last_a = imem_addr;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      check("wait_init", 64'(initialize), 64'd1);
      check("wait_cpu_rst", 64'(cpu_rst), 64'd1);
      check("wait_rdy", 64'(s_ready), 64'd0);
      if (imem_addr != last_a) begin
        check("pad_addr", 64'(imem_addr), 64'(waddr(n + pads)));
        check("pad_data", 64'(imem_data), 64'(HALT));
        pads++;
        last_a = imem_addr;
      end
    end
    check("rel_done", 64'(done), 64'd1);
    check("rel_init", 64'(initialize), 64'd0);
    check("rel_cpu_rst", 64'(cpu_rst), 64'd0);
`ifdef PAD_HALT_EN
    check("pad_count", 64'(pads), 64'(DEPTH - n));
    check("final_wc", 64'(word_count), 64'(DEPTH));
`else
    check("pad_count", 64'(pads), 64'd0);
    check("latency", 64'(cyc), 64'd3);
    check("final_wc", 64'(word_count), 64'(n));
`endif
    repeat (2) begin
      @(negedge clk);
      check("run_done", 64'(done), 64'd1);
      check("run_cpu_rst", 64'(cpu_rst), 64'd0);
      check("run_init", 64'(initialize), 64'd0);
      check("run_rdy", 64'(s_ready), 64'd0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset_values("reset");
    rst = 1;
    @(negedge clk);
    check("idle_rdy", 64'(s_ready), 64'd0);
    load(DEPTH, 1, -1);
    load(2, 1, -1);
    load(3, 1, -1);
    load(5, 1, 2);
    reset_values("post_abort");
    load(4, 1, -1);
    load(DEPTH + 1, 0, -1);
    load(3, 1, -1);
    repeat (4) load($urandom_range(1, DEPTH), 1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
